// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode map, instruction-class indices and FSM/mux enums for the accumulator CPU control.
package cpu_ctrl_pkg;

    localparam int OP_NOP    = 'h00;
    localparam int OP_LDAC   = 'h01;
    localparam int OP_STAC   = 'h02;
    localparam int OP_MVAC   = 'h03;
    localparam int OP_MOVR   = 'h04;
    localparam int OP_JUMP   = 'h05;
    localparam int OP_JMPZ   = 'h06;
    localparam int OP_JPNZ   = 'h07;
    localparam int OP_ALU_LO = 'h08;
    localparam int OP_ALU_HI = 'h0F;
    localparam int OP_HALT   = 'hFF;

    // bit positions of the one-hot instruction class vector
    localparam int C_NOP  = 0;
    localparam int C_LDAC = 1;
    localparam int C_STAC = 2;
    localparam int C_MVAC = 3;
    localparam int C_MOVR = 4;
    localparam int C_JUMP = 5;
    localparam int C_JMPZ = 6;
    localparam int C_JPNZ = 7;
    localparam int C_ALU  = 8;
    localparam int C_HALT = 9;
    localparam int NCLS   = 10;

    typedef enum logic [3:0] {
        S_FETCH_A, S_DECODE, S_ALU, S_MVAC, S_MOVR, S_HALT,
        S_SKIP, S_ADDR, S_JMP, S_RD, S_LDDR, S_WR
    } state_t;

    typedef enum logic [1:0] {AC_ALU = 2'd0, AC_DR = 2'd1, AC_R = 2'd2} ac_sel_t;

endpackage

// File: rtl/op_decode.sv
// op_decode: combinational opcode to one-hot instruction class; no class hit means illegal.
module op_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W = 8
) (
    input  logic [OP_W-1:0] i_opcode,
    output logic [NCLS-1:0] o_cls,
    output logic            o_illegal
);

    always_comb begin
        o_cls         = '0;
        o_cls[C_NOP]  = i_opcode == OP_W'(OP_NOP);
        o_cls[C_LDAC] = i_opcode == OP_W'(OP_LDAC);
        o_cls[C_STAC] = i_opcode == OP_W'(OP_STAC);
        o_cls[C_MVAC] = i_opcode == OP_W'(OP_MVAC);
        o_cls[C_MOVR] = i_opcode == OP_W'(OP_MOVR);
        o_cls[C_JUMP] = i_opcode == OP_W'(OP_JUMP);
        o_cls[C_JMPZ] = i_opcode == OP_W'(OP_JMPZ);
        o_cls[C_JPNZ] = i_opcode == OP_W'(OP_JPNZ);
        o_cls[C_ALU]  = i_opcode >= OP_W'(OP_ALU_LO) && i_opcode <= OP_W'(OP_ALU_HI);
        o_cls[C_HALT] = i_opcode == OP_W'(OP_HALT);
        o_illegal     = ~|o_cls;
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control FSM for the accumulator CPU with req/ready memory handshake,
// parametrised address-operand bytes, HALT, sticky illegal-opcode flag and run gating.
module mc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_BYTES = 2,
    parameter int OP_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [OP_W-1:0]       opcode,
    input  logic                  z,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  sel_addr,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic                  ir_we,
    output logic                  dr_we,
    output logic [ADDR_BYTES-1:0] addr_we,
    output logic                  ac_we,
    output logic                  r_we,
    output logic                  z_we,
    output logic [1:0]            sel_ac,
    output logic                  halted,
    output logic                  illegal
);

    localparam int CW = $clog2(ADDR_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(ADDR_BYTES - 1);

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_pend, w_pend_nxt;
    logic            r_illegal, w_set_ill;
    logic [NCLS-1:0] w_cls;
    logic            w_ill;
    ac_sel_t         w_sel_ac;

    op_decode #(.OP_W(OP_W)) u_dec (
        .i_opcode  (opcode),
        .o_cls     (w_cls),
        .o_illegal (w_ill)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH_A;
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_nxt;
            r_pend    <= w_pend_nxt;
            r_illegal <= r_illegal | w_set_ill;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = r_cnt;
        w_pend_nxt = 1'b0;
        w_set_ill  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        sel_addr   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        ir_we      = 1'b0;
        dr_we      = 1'b0;
        addr_we    = '0;
        ac_we      = 1'b0;
        r_we       = 1'b0;
        z_we       = 1'b0;
        w_sel_ac   = AC_ALU;
        halted     = 1'b0;
        case (r_state)
            S_FETCH_A: begin
                // once issued, a fetch stays requested even if run drops; reset kills it at once
                mem_req    = (run | r_pend) & ~reset;
                ir_we      = mem_req & mem_ready;
                pc_inc     = ir_we;
                w_pend_nxt = mem_req & ~mem_ready;
                if (ir_we) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_cnt_nxt = '0;
                if (w_cls[C_NOP] | w_ill) begin
                    w_set_ill = w_ill;
                    w_next    = S_FETCH_A;
                end
                else if (w_cls[C_HALT]) w_next = S_HALT;
                else if (w_cls[C_ALU])  w_next = S_ALU;
                else if (w_cls[C_MVAC]) w_next = S_MVAC;
                else if (w_cls[C_MOVR]) w_next = S_MOVR;
                else if ((w_cls[C_JMPZ] & ~z) | (w_cls[C_JPNZ] & z)) w_next = S_SKIP;
                else if (w_cls[C_LDAC] | w_cls[C_STAC] | w_cls[C_JUMP] | w_cls[C_JMPZ] | w_cls[C_JPNZ])
                    w_next = S_ADDR;
            end
            S_ADDR: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    addr_we   = ADDR_BYTES'(1) << r_cnt;
                    pc_inc    = 1'b1;
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == LAST) w_next = w_cls[C_LDAC] ? S_RD : w_cls[C_STAC] ? S_WR : S_JMP;
                end
            end
            S_SKIP: begin
                pc_inc    = 1'b1;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == LAST) w_next = S_FETCH_A;
            end
            S_JMP: begin
                pc_load = 1'b1;
                w_next  = S_FETCH_A;
            end
            S_RD: begin
                mem_req  = 1'b1;
                sel_addr = 1'b1;
                dr_we    = mem_ready;
                if (mem_ready) w_next = S_LDDR;
            end
            S_LDDR: begin
                ac_we    = 1'b1;
                w_sel_ac = AC_DR;
                w_next   = S_FETCH_A;
            end
            S_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                sel_addr = 1'b1;
                if (mem_ready) w_next = S_FETCH_A;
            end
            S_ALU: begin
                ac_we  = 1'b1;
                z_we   = 1'b1;
                w_next = S_FETCH_A;
            end
            S_MVAC: begin
                r_we   = 1'b1;
                w_next = S_FETCH_A;
            end
            S_MOVR: begin
                ac_we    = 1'b1;
                w_sel_ac = AC_R;
                w_next   = S_FETCH_A;
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_FETCH_A;
        endcase
    end

    assign sel_ac  = w_sel_ac;
    assign illegal = r_illegal;

endmodule
